// File: rtl/serial_adder_ctrl_pkg.sv
// Shared constants for the bit-serial adder controller: FSM state codes and default width.
package serial_adder_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// Combinational 1-bit full-adder cell, time-shared by the serial adder controller.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c_in;
  assign carry = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell swept LSB-first over WIDTH cycles.
// Optional subtract mode (port sub) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] s_msb;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  full_adder_cell u_cell (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .c_in  (carry),
    .sum   (fa_s),
    .carry (fa_co)
  );

  // New sum bit placed at the MSB so that after WIDTH shifts bit 0 lands at the LSB.
  always_comb begin
    s_msb            = '0;
    s_msb[WIDTH-1]   = fa_s;
  end

  // Subtraction is a + ~b + 1, so only the loaded B and initial carry differ.
  always_comb begin
    b_load     = b;
    carry_load = c_in;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_load     = ~b;
      carry_load = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            b_sr  <= b_load;
            carry <= carry_load;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_sr <= (sum_sr >> 1) | s_msb;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= fa_co;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_RUN) || (state == ST_DONE);
  assign sum       = sum_sr;
  assign c_out     = carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: arithmetic/timing reference model plus directed
// literal cases, random operations, and an exhaustive WIDTH=2 sweep on a second instance.
module tb_serial_adder_ctrl;
  import serial_adder_ctrl_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         busy;

  logic         in_valid2;
  logic         in_ready2;
  logic [1:0]   a2;
  logic [1:0]   b2;
  logic         c_in2;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub2;
`endif
  logic         out_valid2;
  logic         out_ready2;
  logic [1:0]   sum2;
  logic         c_out2;
  logic         busy2;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: one operation in flight, with its accept cycle and result.
  int           cyc    = 0;
  bit           chk_en = 1'b0;
  bit           m_pend = 1'b0;
  int           m_acc  = 0;
  logic [W:0]   m_exp  = '0;
  bit           m_ov;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .busy      (busy)
  );

  serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .a         (a2),
    .b         (b2),
    .c_in      (c_in2),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub2),
`endif
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .sum       (sum2),
    .c_out     (c_out2),
    .busy      (busy2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result of one operation as plain arithmetic on the operands.
  function automatic logic [W:0] ref_result(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                            input logic rc, input logic rs);
    logic [W:0] r;
    r = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
`ifdef SERIAL_ADDER_SUB_EN
    if (rs) r = {1'b0, ra} + {1'b0, ~rb} + {{W{1'b0}}, 1'b1};
`endif
    return r;
  endfunction

  always @(posedge clk) begin
    logic s_now;
    cyc++;
    s_now = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    s_now = sub;
`endif
    if (!rst_n) begin
      m_pend = 1'b0;
    end else if (!m_pend) begin
      if (in_valid) begin
        m_pend = 1'b1;
        m_acc  = cyc;
        m_exp  = ref_result(a, b, c_in, s_now);
      end
    end else if ((cyc - 1 - m_acc >= W) && out_ready) begin
      m_pend = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      m_ov = m_pend && (cyc - m_acc >= W);
      check("model_in_ready", in_ready, !m_pend);
      check("model_busy", busy, m_pend);
      check("model_out_valid", out_valid, m_ov);
      if (m_ov) begin
        check("model_sum", sum, m_exp[W-1:0]);
        check("model_c_out", c_out, m_exp[W]);
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                               input logic tc, input logic ts, input int hold,
                               input logic [W:0] exp);
    int lat;
    @(negedge clk);
    a = ta; b = tb_v; c_in = tc; in_valid = 1'b1; out_ready = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = ts;
`endif
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom);
    while (!out_valid && lat < 50) begin
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", lat, W);
    checkOutput(exp);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a = W'($urandom);
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_sum", sum, exp[W-1:0]);
      check("hold_c_out", c_out, exp[W]);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drain_in_ready", in_ready, 1);
    check("drain_out_valid", out_valid, 0);
  endtask

  task automatic checkOutput(input logic [W:0] exp);
    check("op_sum", sum, exp[W-1:0]);
    check("op_c_out", c_out, exp[W]);
  endtask

  task automatic applyStimulus2(input logic [1:0] ta, input logic [1:0] tb_v, input logic tc);
    int lat;
    logic [2:0] exp;
    exp = {1'b0, ta} + {1'b0, tb_v} + {2'b00, tc};
    @(negedge clk);
    a2 = ta; b2 = tb_v; c_in2 = tc; in_valid2 = 1'b1;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    in_valid2 = 1'b0;
    while (!out_valid2 && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("w2_latency", lat, 2);
    check("w2_result", {c_out2, sum2}, exp);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b0;
    in_valid2 = 1'b0; a2 = '0; b2 = '0; c_in2 = 1'b0; out_ready2 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0; sub2 = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_c_out", c_out, 0);
    rst_n = 1'b1;

    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 0, 9'h100);
    applyStimulus(8'h5A, 8'h3C, 1'b1, 1'b0, 0, 9'h097);
    applyStimulus(8'hC3, 8'h81, 1'b1, 1'b0, 10, 9'h145);

    // Abort an operation four cycles into RUN; its result must never appear.
    @(negedge clk);
    a = 8'hAA; b = 8'h55; c_in = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_sum", sum, 0);
    check("abort_in_ready", in_ready, 1);
    rst_n = 1'b1;
    applyStimulus(8'h01, 8'h02, 1'b0, 1'b0, 0, 9'h003);

`ifdef SERIAL_ADDER_SUB_EN
    applyStimulus(8'h10, 8'h01, 1'b0, 1'b1, 0, 9'h10F);
    applyStimulus(8'h00, 8'h01, 1'b1, 1'b1, 0, 9'h0FF);
`endif

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rc, 1'b0, int'($urandom_range(0, 3)), ref_result(ra, rb, rc, 1'b0));
    end

    for (int i = 0; i < 32; i++) begin
      applyStimulus2(2'(i >> 3), 2'(i >> 1), 1'(i));
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
